// File: rtl/can_bit_timing_if.sv
// Bus between the bit-timing sequencer and its user: configuration, the
// time-quantum strobe and RX level in; segment strobes and state out.
interface can_bit_timing_if;
  logic       enable;
  logic       tq_pulse;
  logic       rx;
  logic       hard_sync_en;
  logic [4:0] tseg1;
  logic [3:0] tseg2;
  logic [2:0] sjw;
  logic       sample_point;
  logic       sampled_bit;
  logic       bit_start;
  logic       hard_sync;
  logic [1:0] seg_state;

  modport master (
    output enable, tq_pulse, rx, hard_sync_en, tseg1, tseg2, sjw,
    input  sample_point, sampled_bit, bit_start, hard_sync, seg_state
  );

  modport slave (
    input  enable, tq_pulse, rx, hard_sync_en, tseg1, tseg2, sjw,
    output sample_point, sampled_bit, bit_start, hard_sync, seg_state
  );
endinterface

// File: rtl/can_bit_timing.sv
// CAN nominal bit-timing sequencer. Splits each bit into SYNC_SEG, TSEG1 and
// TSEG2 on time-quantum strobes, emits sample-point / bit-start strobes and
// applies hard sync and SJW-limited resync on recessive-to-dominant edges.
//
// state | meaning
// SYNC  | one-TQ synchronization segment, bit starts here
// TSEG1 | propagation + phase 1, sample point at its end
// TSEG2 | phase 2, bit ends here
module can_bit_timing (
  input  logic            clock,
  input  logic            reset_n,
  can_bit_timing_if.slave bus
);
  typedef enum logic [1:0] {
    ST_SYNC  = 2'b00,
    ST_TSEG1 = 2'b01,
    ST_TSEG2 = 2'b10
  } seg_t;

  seg_t       r_state, w_state_nx;
  logic [4:0] r_tq_cnt, w_tq_cnt_nx;
  logic [2:0] r_ext, w_ext_nx;
  logic [2:0] r_shorten, w_shorten_nx;
  logic       r_sync_done, w_sync_done_nx;
  logic       r_rx_prev, w_rx_prev_nx;
  logic       r_sample_point, w_sample_point_nx;
  logic       r_sampled_bit, w_sampled_bit_nx;
  logic       r_bit_start, w_bit_start_nx;
  logic       r_hard_sync, w_hard_sync_nx;

  logic [4:0] w_tseg1_eff;
  logic [3:0] w_tseg2_eff;
  logic [2:0] w_sjw_lim;
  logic [2:0] w_sjw_eff;
  logic       w_falling;
  logic       w_hard;
  logic       w_resync;
  logic       w_early_end;
  logic [4:0] w_remaining;
  logic [2:0] w_late_ext;
  logic [2:0] w_ext_upd;
  logic [2:0] w_shorten_upd;
  logic [4:0] w_seg1_len;
  logic [4:0] w_seg2_diff;
  logic [4:0] w_seg2_len;

  // Clamp the segment lengths and jump width into their legal ranges
  always_comb begin
    if (bus.tseg1 < 5'd2)
      w_tseg1_eff = 5'd2;
    else if (bus.tseg1 > 5'd16)
      w_tseg1_eff = 5'd16;
    else
      w_tseg1_eff = bus.tseg1;

    if (bus.tseg2 == 4'd0)
      w_tseg2_eff = 4'd1;
    else if (bus.tseg2 > 4'd8)
      w_tseg2_eff = 4'd8;
    else
      w_tseg2_eff = bus.tseg2;

    if (bus.sjw == 3'd0)
      w_sjw_lim = 3'd1;
    else if (bus.sjw > 3'd4)
      w_sjw_lim = 3'd4;
    else
      w_sjw_lim = bus.sjw;

    // sjw_lim never exceeds 4, so the narrowed tseg2 is only taken when it is < 4
    if ({1'b0, w_sjw_lim} > w_tseg2_eff)
      w_sjw_eff = w_tseg2_eff[2:0];
    else
      w_sjw_eff = w_sjw_lim;
  end

  assign w_falling   = r_rx_prev & ~bus.rx;
  assign w_hard      = w_falling & bus.hard_sync_en;
  assign w_resync    = w_falling & ~bus.hard_sync_en & ~r_sync_done & r_sampled_bit;
  assign w_remaining = {1'b0, w_tseg2_eff} - r_tq_cnt;
  assign w_early_end = w_resync && (r_state == ST_TSEG2) &&
                       (w_remaining <= {2'b00, w_sjw_eff});
  // Late edge: phase error is the TQs already spent in TSEG1, capped at SJW
  assign w_late_ext  = ((r_tq_cnt + 5'd1) > {2'b00, w_sjw_eff}) ? w_sjw_eff
                                                                : (r_tq_cnt[2:0] + 3'd1);

  // Phase-error correction taken this cycle, visible to the same-cycle compare
  always_comb begin
    w_ext_upd     = r_ext;
    w_shorten_upd = r_shorten;
    if (w_resync && (r_state == ST_TSEG1))
      w_ext_upd = w_late_ext;
    if (w_resync && (r_state == ST_TSEG2) && !w_early_end)
      w_shorten_upd = w_sjw_eff;
  end

  assign w_seg1_len  = w_tseg1_eff + {2'b00, w_ext_upd};
  assign w_seg2_diff = {1'b0, w_tseg2_eff} - {2'b00, w_shorten_upd};
  assign w_seg2_len  = ({1'b0, w_tseg2_eff} > {2'b00, w_shorten_upd}) ? w_seg2_diff : 5'd1;

  // Next-state and strobe decode; sync events take priority over the TQ advance
  always_comb begin
    w_state_nx        = r_state;
    w_tq_cnt_nx       = r_tq_cnt;
    w_ext_nx          = w_ext_upd;
    w_shorten_nx      = w_shorten_upd;
    w_sync_done_nx    = r_sync_done | w_resync;
    w_rx_prev_nx      = bus.rx;
    w_sample_point_nx = 1'b0;
    w_sampled_bit_nx  = r_sampled_bit;
    w_bit_start_nx    = 1'b0;
    w_hard_sync_nx    = 1'b0;

    if (!bus.enable) begin
      w_state_nx       = ST_SYNC;
      w_tq_cnt_nx      = 5'd0;
      w_ext_nx         = 3'd0;
      w_shorten_nx     = 3'd0;
      w_sync_done_nx   = 1'b0;
      w_rx_prev_nx     = 1'b1;
      w_sampled_bit_nx = 1'b1;
    end else if (w_hard) begin
      w_state_nx     = ST_SYNC;
      w_tq_cnt_nx    = 5'd0;
      w_ext_nx       = 3'd0;
      w_shorten_nx   = 3'd0;
      w_sync_done_nx = 1'b1;
      w_bit_start_nx = 1'b1;
      w_hard_sync_nx = 1'b1;
    end else if (w_early_end) begin
      // Early edge close enough to the bit end: it becomes the new SYNC_SEG
      w_state_nx     = ST_SYNC;
      w_tq_cnt_nx    = 5'd0;
      w_shorten_nx   = 3'd0;
      w_bit_start_nx = 1'b1;
    end else if (bus.tq_pulse) begin
      case (r_state)
        ST_SYNC: begin
          w_state_nx  = ST_TSEG1;
          w_tq_cnt_nx = 5'd0;
        end
        ST_TSEG1: begin
          if (r_tq_cnt == (w_seg1_len - 5'd1)) begin
            w_state_nx        = ST_TSEG2;
            w_tq_cnt_nx       = 5'd0;
            w_sample_point_nx = 1'b1;
            w_sampled_bit_nx  = bus.rx;
            w_sync_done_nx    = 1'b0;
            w_ext_nx          = 3'd0;
          end else begin
            w_tq_cnt_nx = r_tq_cnt + 5'd1;
          end
        end
        ST_TSEG2: begin
          if (r_tq_cnt == (w_seg2_len - 5'd1)) begin
            w_state_nx     = ST_SYNC;
            w_tq_cnt_nx    = 5'd0;
            w_bit_start_nx = 1'b1;
            w_shorten_nx   = 3'd0;
          end else begin
            w_tq_cnt_nx = r_tq_cnt + 5'd1;
          end
        end
        default: begin
          w_state_nx  = ST_SYNC;
          w_tq_cnt_nx = 5'd0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_SYNC;
      r_tq_cnt       <= 5'd0;
      r_ext          <= 3'd0;
      r_shorten      <= 3'd0;
      r_sync_done    <= 1'b0;
      r_rx_prev      <= 1'b1;
      r_sample_point <= 1'b0;
      r_sampled_bit  <= 1'b1;
      r_bit_start    <= 1'b0;
      r_hard_sync    <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_tq_cnt       <= w_tq_cnt_nx;
      r_ext          <= w_ext_nx;
      r_shorten      <= w_shorten_nx;
      r_sync_done    <= w_sync_done_nx;
      r_rx_prev      <= w_rx_prev_nx;
      r_sample_point <= w_sample_point_nx;
      r_sampled_bit  <= w_sampled_bit_nx;
      r_bit_start    <= w_bit_start_nx;
      r_hard_sync    <= w_hard_sync_nx;
    end
  end

  assign bus.sample_point = r_sample_point;
  assign bus.sampled_bit  = r_sampled_bit;
  assign bus.bit_start    = r_bit_start;
  assign bus.hard_sync    = r_hard_sync;
  assign bus.seg_state    = r_state;
endmodule

// File: tb/tb_can_bit_timing.sv
// Directed bench for can_bit_timing: a table of timing configurations
// (with optional late edges) plus hand-written sync / reset sequences.
module tb_can_bit_timing;
  logic clock = 1'b0;
  logic reset_n;

  can_bit_timing_if bus();

  can_bit_timing dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] tseg1;
    logic [3:0] tseg2;
    logic [2:0] sjw;
    int         edge_tq;  // TSEG1 tq_cnt at which a late edge is injected, -1 none
    int         exp_nom;  // TQs from reset release to first bit_start
    int         exp_sp;   // TQs from bit_start to sample_point in measured bit
    int         exp_bit;  // TQs from bit_start to next bit_start in measured bit
  } vec_t;

  int errors = 0;
  int checks = 0;
  int tq_count = 0;
  int phase = 0;
  int t0, t1, ta, base;
  vec_t vecs[10];
  int exp_seq[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; outputs are read 1ns after the edge, tq_pulse every 4th clock
  task automatic step();
    @(posedge clock);
    #1;
    if (bus.tq_pulse) tq_count++;
    phase = (phase + 1) % 4;
    bus.tq_pulse = (phase == 0);
  endtask

  // which: 0 = bit_start, 1 = sample_point
  task automatic wait_event(input string name, input int which, output int tq_at);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      if (which == 0) seen = (bus.bit_start == 1'b1);
      else            seen = (bus.sample_point == 1'b1);
    end
    tq_at = tq_count;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: strobe absent, got none within 400 clocks, expected one", name);
    end
  endtask

  task automatic wait_tq(input int target);
    for (int i = 0; i < 400 && tq_count < target; i++) step();
    if (tq_count != target) begin
      checks++;
      errors++;
      $display("FAIL wait_tq: tq count %0d expected %0d", tq_count, target);
    end
  endtask

  task automatic do_reset(input logic [4:0] t1v, input logic [3:0] t2v,
                          input logic [2:0] sj, output int b);
    bus.tseg1 = t1v;
    bus.tseg2 = t2v;
    bus.sjw = sj;
    bus.rx = 1'b1;
    bus.hard_sync_en = 1'b0;
    bus.enable = 1'b1;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    b = tq_count;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{5'd5,  4'd2,  3'd1, -1,  8,  6,  8};
    vecs[1] = '{5'd0,  4'd0,  3'd0, -1,  4,  3,  4};
    vecs[2] = '{5'd20, 4'd15, 3'd7, -1, 25, 17, 25};
    vecs[3] = '{5'd16, 4'd8,  3'd4, -1, 25, 17, 25};
    vecs[4] = '{5'd2,  4'd1,  3'd1, -1,  4,  3,  4};
    vecs[5] = '{5'd1,  4'd9,  3'd3, -1, 11,  3, 11};
    vecs[6] = '{5'd5,  4'd2,  3'd2,  3,  8,  8, 10};
    vecs[7] = '{5'd5,  4'd1,  3'd4,  3,  7,  7,  8};
    vecs[8] = '{5'd5,  4'd8,  3'd7,  4, 14, 10, 18};
    vecs[9] = '{5'd5,  4'd2,  3'd0,  2,  8,  7,  9};
    exp_seq = '{1, 1, 1, 1, 1, 2, 2, 0};

    reset_n = 1'b0;
    bus.enable = 1'b1;
    bus.tq_pulse = 1'b0;
    bus.rx = 1'b1;
    bus.hard_sync_en = 1'b0;
    bus.tseg1 = 5'd5;
    bus.tseg2 = 4'd2;
    bus.sjw = 3'd1;
    step();
    step();
    check("rst_sample_point", bus.sample_point, 0);
    check("rst_bit_start", bus.bit_start, 0);
    check("rst_hard_sync", bus.hard_sync, 0);
    check("rst_sampled_bit", bus.sampled_bit, 1);
    check("rst_seg_state", bus.seg_state, 0);

    // Configuration table: free-run and single late edges
    for (int v = 0; v < 10; v++) begin
      do_reset(vecs[v].tseg1, vecs[v].tseg2, vecs[v].sjw, base);
      wait_event($sformatf("v%0d_first_bs", v), 0, t0);
      check($sformatf("v%0d_first_bit", v), t0 - base, vecs[v].exp_nom);
      if (vecs[v].edge_tq >= 0) begin
        wait_tq(t0 + 1 + vecs[v].edge_tq);
        bus.rx = 1'b0;
        step();
        bus.rx = 1'b1;
      end
      wait_event($sformatf("v%0d_sp", v), 1, ta);
      check($sformatf("v%0d_sample_tq", v), ta - t0, vecs[v].exp_sp);
      check($sformatf("v%0d_sampled_bit", v), bus.sampled_bit, 1);
      wait_event($sformatf("v%0d_bs", v), 0, t1);
      check($sformatf("v%0d_bit_tq", v), t1 - t0, vecs[v].exp_bit);
    end

    // seg_state across one nominal bit
    do_reset(5'd5, 4'd2, 3'd1, base);
    wait_event("seq_bs", 0, t0);
    check("seq_state_bs", bus.seg_state, 0);
    for (int k = 1; k <= 8; k++) begin
      wait_tq(t0 + k);
      check($sformatf("seq_state_tq%0d", k), bus.seg_state, exp_seq[k-1]);
    end

    // Hard sync in TSEG1 at tq_cnt 2
    do_reset(5'd5, 4'd2, 3'd1, base);
    wait_event("hs_bs", 0, t0);
    wait_tq(t0 + 3);
    bus.rx = 1'b0;
    bus.hard_sync_en = 1'b1;
    step();
    check("hs_hard_sync", bus.hard_sync, 1);
    check("hs_bit_start", bus.bit_start, 1);
    check("hs_seg_state", bus.seg_state, 0);
    t1 = tq_count;
    bus.hard_sync_en = 1'b0;
    step();
    check("hs_strobe_width", bus.hard_sync, 0);
    wait_event("hs_sp", 1, ta);
    check("hs_sample_tq", ta - t1, 6);
    check("hs_sampled_bit", bus.sampled_bit, 0);
    bus.rx = 1'b1;

    // Early edge at TSEG2 tq_cnt 0 shortens phase 2 by one TQ
    do_reset(5'd5, 4'd3, 3'd1, base);
    wait_event("ee0_first_bs", 0, t0);
    check("ee0_nominal", t0 - base, 9);
    wait_tq(t0 + 6);
    bus.rx = 1'b0;
    step();
    bus.rx = 1'b1;
    wait_event("ee0_bs", 0, t1);
    check("ee0_bit_tq", t1 - t0, 8);

    // Early edge at TSEG2 tq_cnt 2 ends the bit immediately
    wait_tq(t1 + 8);
    bus.rx = 1'b0;
    step();
    check("ee2_bit_start", bus.bit_start, 1);
    check("ee2_seg_state", bus.seg_state, 0);
    ta = tq_count;
    bus.rx = 1'b1;
    wait_event("ee2_sp", 1, t0);
    check("ee2_sample_tq", t0 - ta, 6);

    // Second edge in the same bit after a resync is ignored
    do_reset(5'd5, 4'd3, 3'd1, base);
    wait_event("ig_bs", 0, t0);
    bus.rx = 1'b0;
    step();
    bus.rx = 1'b1;
    wait_tq(t0 + 4);
    bus.rx = 1'b0;
    step();
    bus.rx = 1'b1;
    wait_event("ig_sp", 1, ta);
    check("ig_second_edge_sp", ta - t0, 6);
    wait_event("ig_bs2", 0, t1);
    check("ig_second_edge_bit", t1 - t0, 9);

    // Edge while sampled_bit is dominant is ignored
    do_reset(5'd5, 4'd3, 3'd1, base);
    wait_event("sb0_bs", 0, t0);
    bus.rx = 1'b0;
    wait_event("sb0_sp", 1, ta);
    check("sb0_sampled_bit", bus.sampled_bit, 0);
    bus.rx = 1'b1;
    step();
    wait_tq(t0 + 8);
    bus.rx = 1'b0;
    step();
    check("sb0_no_early_end", bus.bit_start, 0);
    bus.rx = 1'b1;
    wait_event("sb0_bs2", 0, t1);
    check("sb0_bit_tq", t1 - t0, 9);

    // Asynchronous reset in TSEG2
    do_reset(5'd5, 4'd2, 3'd1, base);
    wait_event("rs_bs", 0, t0);
    bus.rx = 1'b0;
    wait_event("rs_sp", 1, ta);
    step();
    check("rs_pre_seg_state", bus.seg_state, 2);
    reset_n = 1'b0;
    #1;
    check("rs_sampled_bit", bus.sampled_bit, 1);
    check("rs_seg_state", bus.seg_state, 0);
    check("rs_sample_point", bus.sample_point, 0);
    check("rs_bit_start", bus.bit_start, 0);
    check("rs_hard_sync", bus.hard_sync, 0);
    bus.rx = 1'b1;
    step();
    reset_n = 1'b1;
    base = tq_count;
    wait_event("rs_first_bs", 0, t1);
    check("rs_first_bit", t1 - base, 8);

    // Enable dropped mid-bit for 10 clocks
    do_reset(5'd5, 4'd2, 3'd1, base);
    wait_event("en_bs", 0, t0);
    bus.rx = 1'b0;
    wait_event("en_sp", 1, ta);
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("en_seg_state", bus.seg_state, 0);
    check("en_sampled_bit", bus.sampled_bit, 1);
    bus.rx = 1'b1;
    bus.enable = 1'b1;
    base = tq_count;
    wait_event("en_first_bs", 0, t1);
    check("en_first_bit", t1 - base, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/can_bit_timing.md
# can_bit_timing

CAN bit-timing sequencer that consumes the one-clock `tq_pulse` strobe from the time-quantum generator. It divides each nominal bit into SYNC_SEG, TSEG1 (PROP+PHASE1) and TSEG2 (PHASE2) and emits the sample-point and bit-start strobes used by the bit stream processor. It also performs hard synchronization and SJW-limited resynchronization on recessive-to-dominant edges of the synchronized RX line.

## Interface
- No parameters.
- `clock` in 1 — system clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `enable` in 1 — 0 holds block idle (see Operation).
- `tq_pulse` in 1 — one-clock strobe per time quantum.
- `rx` in 1 — synchronized bus level; 0 = dominant.
- `hard_sync_en` in 1 — 1 = next falling edge causes hard sync (bus idle / SOF).
- `tseg1` in 5 — TQs in TSEG1; legal 2..16; values <2 clamp to 2, >16 clamp to 16.
- `tseg2` in 4 — TQs in TSEG2; legal 1..8; 0 clamps to 1, >8 clamps to 8.
- `sjw` in 3 — sync jump width; effective value min(max(sjw,1),4,tseg2_eff).
- `sample_point` out 1 — one-clock strobe at end of TSEG1.
- `sampled_bit` out 1 — `rx` captured at the sample point.
- `bit_start` out 1 — one-clock strobe at start of SYNC_SEG (TX update point).
- `hard_sync` out 1 — one-clock strobe when a hard sync is taken.
- `seg_state` out 2 — 00 SYNC, 01 TSEG1, 10 TSEG2. 11 is never driven.

## Operation
- **Reset / enable=0:** state SYNC, tq_cnt=0, ext=0, shorten=0, sync_done=0, rx_prev=1. Outputs: `sample_point`=0, `bit_start`=0, `hard_sync`=0, `sampled_bit`=1.
- **Edge detect:** `rx_prev` is registered every enabled clock. falling_edge = `rx_prev`=1 and `rx`=0.
- **tq_cnt (5 bits):** counts completed TQs in the current segment and advances only on `tq_pulse`.
- **Segment lengths:** seg1_len = tseg1_eff + ext (max 20). seg2_len = tseg2_eff − shorten (min 1).
- **SYNC:** on `tq_pulse` → TSEG1, tq_cnt=0.
- **TSEG1:** on `tq_pulse`:
  - If tq_cnt = seg1_len−1 → TSEG2, tq_cnt=0, `sample_point`=1, `sampled_bit`←`rx`, sync_done←0, ext←0.
  - Otherwise tq_cnt+1.
- **TSEG2:** on `tq_pulse`:
  - If tq_cnt = seg2_len−1 → SYNC, tq_cnt=0, `bit_start`=1, shorten←0.
  - Otherwise tq_cnt+1.
- **Hard sync** (falling_edge and `hard_sync_en`, any state; ignores sync_done and `sampled_bit`):
  - state←SYNC, tq_cnt←0, ext←0, shorten←0, sync_done←1.
  - `bit_start`=1, `hard_sync`=1.
- **Resync** (falling_edge, `hard_sync_en`=0, sync_done=0, `sampled_bit`=1). Sets sync_done←1 in every case:
  - In SYNC: phase error 0, no timing change.
  - In TSEG1 (late edge): ext←min(tq_cnt+1, sjw_eff).
  - In TSEG2 (early edge): remaining = tseg2_eff − tq_cnt.
    - If remaining ≤ sjw_eff: treated as the new SYNC_SEG — state←SYNC, tq_cnt←0, shorten←0, `bit_start`=1.
    - Otherwise shorten←sjw_eff.
- **Ignored edges:** falling edges with sync_done=1 or `sampled_bit`=0 (non-hard) have no effect.

## Timing
- All outputs are registered. Strobes are high for exactly one clock, in the clock after the `tq_pulse` or edge cycle that caused them.
- **Nominal bit:** 1 + tseg1 + tseg2 TQs. `sample_point` follows the (1+tseg1)-th `tq_pulse` after `bit_start`.
- **Edge and `tq_pulse` in the same clock:**
  - Hard sync and SEG2 early-end override the tq advance.
  - SEG1 extension uses the pre-update tq_cnt; the same-cycle end-of-segment compare uses the new seg1_len.
  - SEG2 shorten compares against the new seg2_len. The remaining > sjw case guarantees tq_cnt < new seg2_len.
- **Mid-operation changes:** `tseg1`, `tseg2` and `sjw` changes take effect at the next compare; the bench holds them stable during a bit.
- **Mid-bit reset or enable drop:** returns to the reset state within 1 clock. Timing restarts at SYNC on the next `tq_pulse`.

## Test plan
All scenarios use `tq_pulse` every 4 clocks, tseg1=5, tseg2=2, sjw=1 unless noted.
- **Free-run, `rx`=1:** `bit_start` every 8 tq_pulses (32 clocks); `sample_point` 6 tq_pulses after each `bit_start`; `sampled_bit`=1; `seg_state` sequence 00,01×5,10×2.
- **Hard sync:** `hard_sync_en`=1, `rx` 1→0 in TSEG1 at tq_cnt=2 → `hard_sync`=1 and `bit_start`=1 next clock, `seg_state`=00; next `sample_point` 6 tq_pulses later with `sampled_bit`=0.
- **Late edge:** sjw=2, `sampled_bit`=1, edge in TSEG1 at tq_cnt=3 → ext=2; `sample_point` at the 8th tq_pulse after `bit_start`; next `bit_start` at the 10th.
- **Early edge:** tseg2=3.
  - Edge at TSEG2 tq_cnt=0 → SEG2 lasts 2 TQs; bit length 8.
  - Edge at tq_cnt=2 → `bit_start` the next clock.
- **Ignored edges:** second edge in the same bit after a resync → no change; edge while `sampled_bit`=0 and `hard_sync_en`=0 → no change.
- **Reset / enable:**
  - `reset_n` low in TSEG2 → all outputs at reset values, `seg_state`=00.
  - `enable`=0 for 10 clocks, then 1 → first `bit_start` at the 8th tq_pulse.
